// File: rtl/cnt_sweep_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package cnt_sweep_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, UP, DOWN} state_t;
   localparam int         WIDTH_DEF = 4;
   localparam logic [7:0] SWEEP_MAX = 8'd255;
endpackage

// File: rtl/cnt_sweep_ctrl.sv
// Drives the reversible lab counter through lo->hi->lo sweeps.
// Optional wrap/carry sanity check enabled with CNT_SWEEP_WRAPCHK_EN.
module cnt_sweep_ctrl
   import cnt_sweep_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [7:0]       reps,
   input  logic [WIDTH-1:0] Q,
   input  logic             Mm,
   input  logic             RCO_,
   output logic             ct_,
   output logic             ld_,
   output logic             mode,
   output logic [WIDTH-1:0] D,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             fault,
   output logic [7:0]       sweeps
);
   state_t           state;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic [7:0]       reps_q, sweeps_q, sweeps_inc;
   logic             chk, stop_pend, done_q, err_q;
   logic             at_hi, at_lo, finish;

   assign at_hi      = (Q == hi_q);
   assign at_lo      = (Q == lo_q);
   assign sweeps_inc = (sweeps_q == SWEEP_MAX) ? sweeps_q : sweeps_q + 8'd1;
   assign finish     = stop_pend || (reps_q != 8'd0 && sweeps_inc == reps_q);

   assign ld_    = (state != LOAD);
   assign busy   = (state != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign D      = lo_q;
   assign sweeps = sweeps_q;

   // Direction turns in the same cycle the bound is seen, so no value repeats.
   always_comb begin
      ct_  = 1'b1;
      mode = 1'b0;
      case (state)
         UP: begin
            ct_  = 1'b0;
            mode = at_hi;
         end
         DOWN: begin
            if (at_lo) begin
               ct_  = finish;
               mode = 1'b0;
            end else begin
               ct_  = 1'b0;
               mode = 1'b1;
            end
         end
         default: begin
            ct_  = 1'b1;
            mode = 1'b0;
         end
      endcase
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         state     <= IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         reps_q    <= '0;
         sweeps_q  <= '0;
         chk       <= 1'b0;
         stop_pend <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (busy && stop) stop_pend <= 1'b1;
         case (state)
            IDLE: begin
               // Bounds are checked the cycle after they are captured.
               if (chk) begin
                  chk <= 1'b0;
                  if (lo_q >= hi_q) begin
                     err_q <= 1'b1;
                  end else begin
                     sweeps_q <= '0;
                     state    <= LOAD;
                  end
               end else if (start) begin
                  lo_q   <= lo;
                  hi_q   <= hi;
                  reps_q <= reps;
                  chk    <= 1'b1;
               end
            end
            LOAD: state <= UP;
            UP:   if (at_hi) state <= DOWN;
            DOWN: begin
               if (at_lo) begin
                  sweeps_q <= sweeps_inc;
                  if (finish) begin
                     state     <= IDLE;
                     done_q    <= 1'b1;
                     stop_pend <= 1'b0;
                  end else begin
                     state <= UP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CNT_SWEEP_WRAPCHK_EN
   logic fault_q, wrap_bad;
   // A carry or max/min flag before reaching the target bound means the counter misbehaved.
   assign wrap_bad = ((state == UP && !at_hi) || (state == DOWN && !at_lo)) && (!RCO_ || Mm);
   always_ff @(posedge cp) begin
      if (rst)           fault_q <= 1'b0;
      else if (wrap_bad) fault_q <= 1'b1;
   end
   assign fault = fault_q;
`else
   logic unused_flags;
   assign unused_flags = ^{Mm, RCO_};
   assign fault        = 1'b0;
`endif
endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: behavioural lab counter, table runs, random runs, corner sequences.
module tb_cnt_sweep_ctrl;
   logic       cp = 1'b0;
   logic       rst, start, stop, force_rco;
   logic [3:0] lo, hi, D;
   logic [3:0] Q = 4'd0;
   logic [7:0] reps, sweeps;
   logic       Mm, RCO_, ct_, ld_, mode, busy, done, err, fault;
   int         nvec = 0, nmis = 0;

`ifdef CNT_SWEEP_WRAPCHK_EN
   localparam int EXP_FAULT = 1;
`else
   localparam int EXP_FAULT = 0;
`endif

   always #5 cp = ~cp;

   // Lab counter: sync load, up/down count, flags per its contract.
   always @(posedge cp) begin
      if (!ld_)      Q <= D;
      else if (!ct_) Q <= mode ? Q - 4'd1 : Q + 4'd1;
   end
   assign Mm   = (!mode && Q == 4'd15) || (mode && Q == 4'd0);
   assign RCO_ = force_rco ? 1'b0 : !(!ct_ && Mm);

   cnt_sweep_ctrl #(.WIDTH(4)) dut (
      .cp(cp), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi), .reps(reps),
      .Q(Q), .Mm(Mm), .RCO_(RCO_), .ct_(ct_), .ld_(ld_), .mode(mode), .D(D),
      .busy(busy), .done(done), .err(err), .fault(fault), .sweeps(sweeps)
   );

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One run from IDLE; called at a negedge. Expected Q trace built from lo/hi/sweep count.
   task automatic run(input string tag, input logic [3:0] l, input logic [3:0] h,
                      input logic [7:0] r, input bit exp_e, input int exp_len, input bit stop_mode);
      int obs[$];
      int mdl[$];
      int nld = 0, ndone = 0, nerrp = 0, tail = -1, mism = -1, nsw, li, hi_i;
      int ld_d = -1;
      bit stopped = 0;
      li   = int'(l);
      hi_i = int'(h);
      nsw  = stop_mode ? 1 : int'(r);
      if (!exp_e) begin
         mdl.push_back(li);
         for (int s = 0; s < nsw; s++) begin
            for (int v = li + 1; v <= hi_i; v++) mdl.push_back(v);
            for (int v = hi_i - 1; v >= li; v--) mdl.push_back(v);
         end
      end
      lo = l; hi = h; reps = r; start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge cp);
         stop = 1'b0; start = 1'b0;
         if (!ld_) begin nld++; ld_d = int'(D); end
         if (busy && ld_) obs.push_back(int'(Q));
         if (done) ndone++;
         if (err) nerrp++;
         if (stop_mode && !stopped && busy && ld_ && !mode && Q == 4'd4) begin
            stop = 1'b1; start = 1'b1; lo = 4'd0; hi = 4'd9; stopped = 1;
         end
         if (tail < 0 && (ndone + nerrp) > 0) tail = 3;
         else if (tail > 0) tail--;
         if (tail == 0) break;
      end
      chk({tag, ".finished"}, (tail == 0) ? 1 : 0, 1);
      chk({tag, ".err_pulses"}, nerrp, exp_e ? 1 : 0);
      chk({tag, ".ld_cycles"}, nld, exp_e ? 0 : 1);
      chk({tag, ".done_pulses"}, ndone, exp_e ? 0 : 1);
      chk({tag, ".q_len"}, obs.size(), exp_len);
      for (int i = 0; i < obs.size() && i < mdl.size(); i++)
         if (mism < 0 && obs[i] != mdl[i]) mism = i;
      if (obs.size() != mdl.size() && mism < 0) mism = (obs.size() < mdl.size()) ? obs.size() : mdl.size();
      chk({tag, ".q_first_diff_idx"}, mism, -1);
      chk({tag, ".busy_end"}, int'(busy), 0);
      if (!exp_e) begin
         chk({tag, ".load_D"}, ld_d, li);
         chk({tag, ".sweeps"}, int'(sweeps), nsw);
      end
   endtask

   typedef struct {
      logic [3:0] lo;
      logic [3:0] hi;
      logic [7:0] reps;
      bit         exp_err;
      int         exp_len;
   } vec_t;

   initial begin
      vec_t tbl[5];
      bit   found;
      tbl[0] = '{4'd2, 4'd5,  8'd1, 1'b0, 7};
      tbl[1] = '{4'd7, 4'd7,  8'd0, 1'b1, 0};
      tbl[2] = '{4'd9, 4'd3,  8'd1, 1'b1, 0};
      tbl[3] = '{4'd0, 4'd15, 8'd2, 1'b0, 61};
      tbl[4] = '{4'd4, 4'd6,  8'd3, 1'b0, 13};

      rst = 1'b1; start = 1'b0; stop = 1'b0; force_rco = 1'b0;
      lo = '0; hi = '0; reps = '0;
      repeat (2) @(negedge cp);
      chk("rst.ct_", int'(ct_), 1);
      chk("rst.ld_", int'(ld_), 1);
      chk("rst.mode", int'(mode), 0);
      chk("rst.D", int'(D), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.err", int'(err), 0);
      chk("rst.fault", int'(fault), 0);
      chk("rst.sweeps", int'(sweeps), 0);
      rst = 1'b0;
      @(negedge cp);

      for (int i = 0; i < 5; i++) begin
         run($sformatf("tbl%0d", i), tbl[i].lo, tbl[i].hi, tbl[i].reps, tbl[i].exp_err, tbl[i].exp_len, 1'b0);
         chk($sformatf("tbl%0d.fault", i), int'(fault), 0);
      end

      run("stop", 4'd2, 4'd5, 8'd0, 1'b0, 7, 1'b1);

      for (int i = 0; i < 12; i++) begin
         logic [3:0] l, h;
         logic [7:0] r;
         bit         e;
         l = 4'($urandom_range(0, 15));
         h = 4'($urandom_range(0, 15));
         r = 8'($urandom_range(1, 3));
         e = (l >= h);
         run($sformatf("rnd%0d", i), l, h, r, e, e ? 0 : 1 + 2 * int'(r) * (int'(h) - int'(l)), 1'b0);
      end

      // Reset while counting down at Q=4.
      lo = 4'd2; hi = 4'd5; reps = 8'd0; start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge cp);
         if (busy && mode && Q == 4'd4) found = 1;
      end
      chk("midrst.reached", int'(found), 1);
      rst = 1'b1;
      @(negedge cp);
      chk("midrst.ct_", int'(ct_), 1);
      chk("midrst.ld_", int'(ld_), 1);
      chk("midrst.mode", int'(mode), 0);
      chk("midrst.busy", int'(busy), 0);
      chk("midrst.sweeps", int'(sweeps), 0);
      rst = 1'b0;
      @(negedge cp);

      // Spurious carry mid-climb.
      lo = 4'd2; hi = 4'd12; reps = 8'd1; start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge cp);
         if (busy && ld_ && !mode && Q == 4'd9) found = 1;
      end
      chk("fault.reached", int'(found), 1);
      force_rco = 1'b1;
      @(negedge cp);
      force_rco = 1'b0;
      chk("fault.rise", int'(fault), EXP_FAULT);
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge cp);
         if (done) found = 1;
      end
      chk("fault.run_done", int'(found), 1);
      chk("fault.hold", int'(fault), EXP_FAULT);
      rst = 1'b1;
      @(negedge cp);
      rst = 1'b0;
      chk("fault.cleared", int'(fault), 0);
      @(negedge cp);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/cnt_sweep_ctrl.md
# cnt_sweep_ctrl

Sequencer that drives the control inputs of the lab 4-bit reversible counter (`ct_`, `ld_`, `mode`, `D`) and watches its outputs (`Q`, `Mm`, `RCO_`). Once started, it loads a lower bound, counts up to an upper bound, reverses, and counts back down. Each lo→hi→lo round trip is one sweep. It runs a programmed number of sweeps, or runs until stopped. It sits between the lab top level (switches/buttons) and the counter instance.

## Interface
- `WIDTH`, default 4: counter data width.
- `cp` in, 1: clock, rising edge; same clock as the counter.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begin a run; sampled only in IDLE.
- `stop` in, 1: finish the current sweep, then go idle; sampled only while busy.
- `lo` in, WIDTH: lower bound; latched on accepted start.
- `hi` in, WIDTH: upper bound; latched on accepted start.
- `reps` in, 8: sweep target; 0 = run until stop; latched on accepted start.
- `Q` in, WIDTH: counter output.
- `Mm` in, 1: counter max/min flag.
- `RCO_` in, 1: counter ripple carry, active low.
- `ct_` out, 1: count enable to counter, active low.
- `ld_` out, 1: synchronous load to counter, active low.
- `mode` out, 1: 0 = up, 1 = down.
- `D` out, WIDTH: load data, equals latched `lo`.
- `busy` out, 1: high in LOAD/UP/DOWN.
- `done` out, 1: one-cycle pulse when a run completes.
- `err` out, 1: one-cycle pulse when start is rejected.
- `fault` out, 1: sticky carry-check flag (see Configuration).
- `sweeps` out, 8: completed sweeps this run, saturating at 255.

## Operation
- Counter contract:
  - `ld_`=0 loads `D` on the edge.
  - Otherwise `ct_`=0 counts one step per edge in the direction given by `mode`.
  - `RCO_` is low when `ct_`=0 and `Q` is 15 (up) or 0 (down).
- States: IDLE, LOAD, UP, DOWN.
- IDLE:
  - Outputs: `ct_`=1, `ld_`=1, `mode`=0.
  - On `start`, latch `lo`, `hi`, `reps`.
  - If latched `lo` >= `hi`: pulse `err`, stay in IDLE.
  - Otherwise clear `sweeps` and go to LOAD.
- LOAD: `ld_`=0, `ct_`=1, `D`=`lo`, for exactly one cycle, then go to UP.
- UP:
  - `ct_`=0.
  - `mode`=0 while `Q`≠`hi`.
  - When `Q`==`hi`: drive `mode`=1 in the same cycle (Mealy on `Q`) and go to DOWN. No value repeats at the turn.
- DOWN:
  - `ct_`=0, `mode`=1 while `Q`≠`lo`.
  - When `Q`==`lo`, the sweep completes and `sweeps` increments.
  - Finish the run if a stop is pending, or if `reps`≠0 and the new `sweeps`==`reps`. Finishing means: drive `ct_`=1 that cycle, pulse `done` next cycle, go to IDLE.
  - Otherwise drive `mode`=0 and `ct_`=0 that cycle and go to UP.
- Stop handling:
  - `stop` sets a pending flag while busy.
  - The flag clears on entry to IDLE.
  - `start` while busy is ignored.
- Reset values:
  - State IDLE.
  - `ct_`=1, `ld_`=1, `mode`=0, `D`=0.
  - `busy`=0, `done`=0, `err`=0, `fault`=0, `sweeps`=0, stop pending cleared.
- Reset mid-run wins immediately. The counter keeps its `Q`.

## Timing
- Edge k samples `start`. LOAD runs in the cycle after edge k+1. The counter shows `Q`=`lo` after edge k+2, with the FSM in UP.
- Counting edges per sweep: 2·(`hi`−`lo`).
- `done` rises one cycle after the last `Q`==`lo` cycle.
- `sweeps` updates on the edge that leaves the `Q`==`lo` DOWN cycle.
- `ct_`/`mode` are combinational from state and `Q`. `ld_`, `done`, `err`, `busy` are decoded from registered state.

## Configuration
- Macro: `CNT_SWEEP_WRAPCHK_EN`.
- Defined: in UP or DOWN, `fault` sets (sticky until `rst`) when either condition holds:
  - `RCO_`==0 while `Q` differs from the bound being approached (`hi` in UP, `lo` in DOWN).
  - `Mm`==1 under the same condition.
- Not defined: `fault` is tied to 0, and `Mm`/`RCO_` are unused.

## Structure
- Package `cnt_sweep_pkg` holds:
  - state enum (IDLE, LOAD, UP, DOWN);
  - default `WIDTH`;
  - `SWEEP_MAX`=255.
- No sub-module. The saturating sweep counter and the bound compares stay inline.

## Test plan
- `lo`=2, `hi`=5, `reps`=1, start:
  - `ld_` low one cycle with `D`=2;
  - `Q` runs 2,3,4,5,4,3,2, then `ct_`=1;
  - `done` pulses once, `sweeps`=1, `busy`=0.
- `reps`=0, `lo`=2, `hi`=5, `stop` pulsed at `Q`=4 rising: counter continues 5,4,3,2, then IDLE; `sweeps`=1; second `start` during run ignored.
- `lo`=7, `hi`=7, start: `err` one-cycle pulse, `ld_` never low, `busy` stays 0.
- `rst` in DOWN at `Q`=4: next cycle `ct_`=1, `ld_`=1, `mode`=0, `busy`=0, `sweeps`=0.
- `lo`=0, `hi`=15, `reps`=2: `mode` flips at `Q`=15 and `Q`=0; `RCO_` lows there raise no `fault`; `sweeps`=2, one `done` pulse.
- With `CNT_SWEEP_WRAPCHK_EN`, `hi`=12: force `RCO_`=0 at `Q`=9 in UP, and `fault` rises and holds until `rst`. Without the macro, `fault` stays 0.
